// File: rtl/core2wb_pipelined.sv
// Ibex core port to pipelined Wishbone B4 master bridge.
// Keeps up to MAX_OUTSTANDING requests in flight in one CYC, with an optional watchdog.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   core_req_i/gnt_o/we_i/be_i       core request handshake and attributes
//   core_addr_i/wdata_i              core address and write data
//   core_rvalid_o/err_o/rdata_o      in-order core response
//   wb_cyc_o/stb_o/we_o/adr_o/sel_o  WB master request
//   wb_dat_o                         WB write data
//   wb_stall_i/ack_i/err_i/dat_i     WB slave response
//   busy_o                           requests outstanding
//   timeout_o                        one-cycle watchdog expiry pulse
module core2wb_pipelined #(
    parameter int AW              = 32,
    parameter int DW              = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            core_req_i,
    output logic            core_gnt_o,
    input  logic            core_we_i,
    input  logic [DW/8-1:0] core_be_i,
    input  logic [AW-1:0]   core_addr_i,
    input  logic [DW-1:0]   core_wdata_i,
    output logic            core_rvalid_o,
    output logic            core_err_o,
    output logic [DW-1:0]   core_rdata_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    output logic [AW-1:0]   wb_adr_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic [DW-1:0]   wb_dat_o,
    input  logic            wb_stall_i,
    input  logic            wb_ack_i,
    input  logic            wb_err_i,
    input  logic [DW-1:0]   wb_dat_i,
    output logic            busy_o,
    output logic            timeout_o
);

    localparam int SW = DW / 8;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit WDOG_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CW-1:0] MAXO = CW'(MAX_OUTSTANDING);
    // Expiry fires in the cycle the counter would reach the limit.
    localparam logic [TW-1:0] TLIM =
        TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic {
        ST_RUN,
        ST_ABORT
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_stb;
    logic            r_we;
    logic [AW-1:0]   r_adr;
    logic [SW-1:0]   r_sel;
    logic [DW-1:0]   r_dat;
    logic [CW-1:0]   r_total;
    logic [CW-1:0]   w_total_nxt;
    logic [TW-1:0]   r_wdog;
    logic [TW-1:0]   w_wdog_nxt;

    logic w_run;
    logic w_busy;
    logic w_gnt;
    logic w_grant;
    logic w_accept;
    logic w_resp;
    logic w_activity;
    logic w_expire;

    assign w_run      = (r_state == ST_RUN);
    assign w_busy     = (r_total != '0);
    // Grant never depends on ack/err: a free slot is only seen a cycle later.
    assign w_gnt      = rst_n & w_run & (!r_stb | !wb_stall_i)
                        & (r_total < MAXO);
    assign w_grant    = core_req_i & w_gnt;
    assign w_accept   = r_stb & !wb_stall_i;
    assign w_resp     = w_run & w_busy & (wb_ack_i | wb_err_i);
    assign w_activity = w_grant | w_accept | wb_ack_i | wb_err_i;
    assign w_expire   = WDOG_EN & w_run & w_busy & !w_activity
                        & (r_wdog == TLIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_total <= '0;
            r_wdog  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_total <= w_total_nxt;
            r_wdog  <= w_wdog_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_total_nxt = r_total;
        w_wdog_nxt  = r_wdog;
        unique case (r_state)
            ST_RUN: begin
                if (w_grant && !w_resp) begin
                    w_total_nxt = r_total + CW'(1);
                end else if (!w_grant && w_resp) begin
                    w_total_nxt = r_total - CW'(1);
                end
                if (!WDOG_EN || w_activity) begin
                    w_wdog_nxt = '0;
                end else if (w_busy) begin
                    w_wdog_nxt = r_wdog + TW'(1);
                end
                if (w_expire) begin
                    w_state_nxt = ST_ABORT;
                    w_wdog_nxt  = '0;
                end
            end
            ST_ABORT: begin
                // One error completion per cycle; bus responses ignored.
                w_total_nxt = r_total - CW'(1);
                w_wdog_nxt  = '0;
                if (r_total == CW'(1)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stb <= 1'b0;
            r_we  <= 1'b0;
            r_adr <= '0;
            r_sel <= '0;
            r_dat <= '0;
        end else begin
            if (w_grant) begin
                r_we  <= core_we_i;
                r_adr <= core_addr_i;
                r_dat <= core_wdata_i;
                r_sel <= core_we_i ? core_be_i : '1;
            end
            if (w_expire) begin
                r_stb <= 1'b0;
            end else if (w_grant) begin
                r_stb <= 1'b1;
            end else if (w_accept) begin
                r_stb <= 1'b0;
            end
        end
    end

    assign core_gnt_o    = w_gnt;
    // ack+err together is reported as an error only.
    assign core_rvalid_o = w_resp & wb_ack_i & !wb_err_i;
    assign core_err_o    = (w_resp & wb_err_i) | (r_state == ST_ABORT);
    assign core_rdata_o  = core_rvalid_o ? wb_dat_i : '0;
    assign wb_cyc_o      = w_run & w_busy;
    assign wb_stb_o      = r_stb;
    assign wb_we_o       = r_we;
    assign wb_adr_o      = r_adr;
    assign wb_sel_o      = r_sel;
    assign wb_dat_o      = r_dat;
    assign busy_o        = w_busy;
    assign timeout_o     = w_expire;

endmodule

// File: tb/tb_core2wb_pipelined.sv
// Scoreboard bench for core2wb_pipelined.
// Directed stimulus; a negedge monitor checks every core response in order.
module tb_core2wb_pipelined;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        core_req_i = 1'b0;
    logic        core_gnt_o;
    logic        core_we_i = 1'b0;
    logic [3:0]  core_be_i = '0;
    logic [31:0] core_addr_i = '0;
    logic [31:0] core_wdata_i = '0;
    logic        core_rvalid_o;
    logic        core_err_o;
    logic [31:0] core_rdata_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;
    logic        wb_stall_i = 1'b0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic [31:0] wb_dat_i = '0;
    logic        busy_o;
    logic        timeout_o;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    core2wb_pipelined #(
        .AW(32),
        .DW(32),
        .MAX_OUTSTANDING(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .core_req_i(core_req_i),
        .core_gnt_o(core_gnt_o),
        .core_we_i(core_we_i),
        .core_be_i(core_be_i),
        .core_addr_i(core_addr_i),
        .core_wdata_i(core_wdata_i),
        .core_rvalid_o(core_rvalid_o),
        .core_err_o(core_err_o),
        .core_rdata_o(core_rdata_o),
        .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o),
        .wb_sel_o(wb_sel_o),
        .wb_dat_o(wb_dat_o),
        .wb_stall_i(wb_stall_i),
        .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i),
        .wb_dat_i(wb_dat_i),
        .busy_o(busy_o),
        .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] a,
                       input logic [63:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_resp(input logic err, input logic [31:0] d);
        exp_t e;
        e.err  = err;
        e.data = d;
        q.push_back(e);
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (rst_n && (core_rvalid_o || core_err_o)) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_resp: got rv=%b err=%b expected none",
                         core_rvalid_o, core_err_o);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("resp_err", 64'(core_err_o), 64'(e.err));
                chk("resp_rvalid", 64'(core_rvalid_o), 64'(!e.err));
                if (!e.err) chk("resp_rdata", 64'(core_rdata_o), 64'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        // Reset state
        #3;
        chk("rst_ctrl",
            64'({core_gnt_o, wb_cyc_o, wb_stb_o, wb_we_o, busy_o,
                 timeout_o, core_rvalid_o, core_err_o}), 64'h0);
        chk("rst_adr_sel", 64'({wb_adr_o, wb_sel_o}), 64'h0);
        chk("rst_dat", 64'({wb_dat_o, core_rdata_o}), 64'h0);
        #20;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Single read, zero-stall slave
        core_req_i = 1'b1; core_we_i = 1'b0; core_be_i = 4'h0;
        core_addr_i = 32'h100;
        @(negedge clk);
        chk("rd_gnt", 64'(core_gnt_o), 64'h1);
        tick();
        core_req_i = 1'b0;
        @(negedge clk);
        chk("rd_stb", 64'({wb_cyc_o, wb_stb_o, wb_we_o}), 64'b110);
        chk("rd_adr", 64'(wb_adr_o), 64'h100);
        chk("rd_sel", 64'(wb_sel_o), 64'hF);
        tick();
        wb_ack_i = 1'b1; wb_dat_i = 32'h1234_5678;
        expect_resp(1'b0, 32'h1234_5678);
        tick();
        wb_ack_i = 1'b0; wb_dat_i = '0;
        @(negedge clk);
        chk("rd_idle", 64'({busy_o, wb_cyc_o, wb_stb_o}), 64'h0);
        tick();

        // Single write with partial byte enables
        core_req_i = 1'b1; core_we_i = 1'b1; core_be_i = 4'b0011;
        core_addr_i = 32'h204; core_wdata_i = 32'hDEAD_BEEF;
        tick();
        core_req_i = 1'b0;
        @(negedge clk);
        chk("wr_sel", 64'(wb_sel_o), 64'h3);
        chk("wr_dat", 64'(wb_dat_o), 64'hDEAD_BEEF);
        chk("wr_we_adr", 64'({wb_we_o, wb_adr_o}), {31'h0, 1'b1, 32'h204});
        tick();
        wb_ack_i = 1'b1;
        expect_resp(1'b0, 32'h0);
        tick();
        wb_ack_i = 1'b0;
        tick();

        // Fill to MAX_OUTSTANDING with req held, no ack
        core_req_i = 1'b1; core_we_i = 1'b0; core_be_i = 4'h0;
        for (int c = 0; c < 6; c++) begin
            core_addr_i = 32'h300 + 32'(4 * c);
            @(negedge clk);
            chk("fill_gnt", 64'(core_gnt_o), 64'(c < 4));
            chk("fill_stb", 64'(wb_stb_o), 64'(c >= 1 && c <= 4));
            if (c >= 1 && c <= 4)
                chk("fill_adr", 64'(wb_adr_o), 64'(32'h300 + 32'(4 * (c - 1))));
            tick();
        end
        core_req_i = 1'b0;
        for (int d = 0; d < 4; d++) begin
            wb_ack_i = 1'b1; wb_dat_i = 32'hA0 + 32'(d);
            expect_resp(1'b0, 32'hA0 + 32'(d));
            @(negedge clk);
            chk("fill_busy", 64'({busy_o, wb_cyc_o}), 64'b11);
            tick();
        end
        wb_ack_i = 1'b0; wb_dat_i = '0;
        @(negedge clk);
        chk("fill_drain", 64'({busy_o, wb_cyc_o, core_gnt_o}), 64'b001);
        tick();

        // Stall the second request for three cycles
        core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 32'h400;
        tick();
        core_we_i = 1'b1; core_be_i = 4'b1100; core_addr_i = 32'h404;
        core_wdata_i = 32'hCAFE_F00D;
        @(negedge clk);
        chk("stall_gnt2", 64'(core_gnt_o), 64'h1);
        tick();
        core_req_i = 1'b0; core_wdata_i = '0; core_addr_i = '0;
        core_be_i = '0;
        wb_stall_i = 1'b1;
        for (int s = 0; s < 3; s++) begin
            if (s == 1) begin
                wb_ack_i = 1'b1; wb_dat_i = 32'hAAAA_5555;
                expect_resp(1'b0, 32'hAAAA_5555);
            end else begin
                wb_ack_i = 1'b0; wb_dat_i = '0;
            end
            @(negedge clk);
            chk("stall_hold",
                64'({wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o[15:0]}),
                64'({1'b1, 1'b1, 4'b1100, 16'h0404}));
            chk("stall_dat", 64'(wb_dat_o), 64'hCAFE_F00D);
            chk("stall_nognt", 64'(core_gnt_o), 64'h0);
            tick();
        end
        wb_ack_i = 1'b0; wb_dat_i = '0; wb_stall_i = 1'b0;
        tick();
        wb_ack_i = 1'b1;
        expect_resp(1'b0, 32'h0);
        tick();
        wb_ack_i = 1'b0;
        @(negedge clk);
        chk("stall_drain", 64'({busy_o, wb_stb_o}), 64'h0);
        tick();

        // Spurious ack while idle
        wb_ack_i = 1'b1; wb_dat_i = 32'h5555_0000;
        @(negedge clk);
        chk("spur_none", 64'({core_rvalid_o, core_err_o, busy_o}), 64'h0);
        tick();
        wb_ack_i = 1'b0; wb_dat_i = '0;

        // ack and err together on one outstanding read
        core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 32'h500;
        tick();
        core_req_i = 1'b0;
        tick();
        wb_ack_i = 1'b1; wb_err_i = 1'b1;
        expect_resp(1'b1, 32'h0);
        @(negedge clk);
        chk("ackerr_out", 64'({core_rvalid_o, core_err_o}), 64'b01);
        tick();
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        @(negedge clk);
        chk("ackerr_once", 64'(busy_o), 64'h0);
        tick();

        // Watchdog: three reads, no response
        for (int c = 0; c < 26; c++) begin
            core_req_i = (c < 3);
            core_addr_i = 32'h600 + 32'(4 * c);
            wb_ack_i = (c == 21);
            if (c >= 20 && c <= 22) expect_resp(1'b1, 32'h0);
            @(negedge clk);
            chk("wd_pulse", 64'(timeout_o), 64'(c == 19));
            if (c >= 20 && c <= 22)
                chk("wd_abort", 64'({wb_cyc_o, wb_stb_o, core_gnt_o}), 64'h0);
            if (c == 23)
                chk("wd_run", 64'({busy_o, core_gnt_o, core_err_o}), 64'b010);
            tick();
        end
        wb_ack_i = 1'b0;

        // Reset mid-transfer
        core_req_i = 1'b1; core_addr_i = 32'h700;
        tick();
        core_req_i = 1'b0;
        #2;
        chk("mid_pre", 64'({wb_cyc_o, wb_stb_o}), 64'b11);
        rst_n = 1'b0;
        #1;
        chk("mid_drop", 64'({wb_cyc_o, wb_stb_o, busy_o}), 64'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wb_ack_i = 1'b1;
        @(negedge clk);
        chk("mid_noresp", 64'({core_rvalid_o, core_err_o}), 64'h0);
        tick();
        wb_ack_i = 1'b0;
        tick();

        chk("queue_empty", 64'(q.size()), 64'h0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
